// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one accumulator pair, 32 iterations per operation.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  func_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, result_q, result_d;
  logic [4:0]  count_q;
  logic        primed_q, neg_q, neg_rem_q, load_result;

  logic        is_div, sign_a, sign_b;
  logic [31:0] mag_a, mag_b, addend;
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, quo_f, rem_f;
  logic [63:0] prod, prod_f;
  logic [33:0] div_sh, div_diff;
  logic        div_ge, div_zero, div_ovf;

  // The first cycle in MUL/DIV (primed_q=0) turns the captured raw operands
  // into magnitudes and screens for the special divide cases.
  always_comb begin
    is_div = func_q[2];
    sign_a = a_q[31] & (is_div ? ~func_q[0] : (func_q[1:0] == 2'b01 || func_q[1:0] == 2'b10));
    sign_b = b_q[31] & (is_div ? ~func_q[0] : (func_q[1:0] == 2'b01));
    mag_a  = sign_a ? -a_q : a_q;
    mag_b  = sign_b ? -b_q : b_q;
    div_zero = (b_q == 32'd0);
    div_ovf  = ~func_q[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);

    addend   = lo_q[0] ? a_q : 32'd0;
    mul_sum  = {1'b0, hi_q} + {1'b0, addend};
    mul_hi_n = mul_sum[32:1];
    mul_lo_n = {mul_sum[0], lo_q[31:1]};
    prod     = {mul_hi_n, mul_lo_n};
    prod_f   = neg_q ? -prod : prod;

    div_sh   = {1'b0, hi_q, lo_q[31]};
    div_diff = div_sh - {2'b00, b_q};
    div_ge   = ~div_diff[33];
    div_hi_n = div_ge ? div_diff[31:0] : div_sh[31:0];
    div_lo_n = {lo_q[30:0], div_ge};
    quo_f    = neg_q ? -div_lo_n : div_lo_n;
    rem_f    = neg_rem_q ? -div_hi_n : div_hi_n;
  end

  always_comb begin
    state_d     = state_q;
    load_result = 1'b0;
    result_d    = result_q;
    case (state_q)
      IDLE: if (start) state_d = func3[2] ? DIV : MUL;
      MUL: begin
        if (primed_q && count_q == 5'd31) begin
          state_d     = DONE;
          load_result = 1'b1;
          result_d    = (func_q[1:0] == 2'b00) ? prod_f[31:0] : prod_f[63:32];
        end
      end
      DIV: begin
        if (!primed_q) begin
          if (div_zero) begin
            state_d     = DONE;
            load_result = 1'b1;
            result_d    = func_q[1] ? a_q : 32'hFFFF_FFFF;
          end else if (div_ovf) begin
            state_d     = DONE;
            load_result = 1'b1;
            result_d    = func_q[1] ? 32'd0 : 32'h8000_0000;
          end
        end else if (count_q == 5'd31) begin
          state_d     = DONE;
          load_result = 1'b1;
          result_d    = func_q[1] ? rem_f : quo_f;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      load_result = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Multiplier keeps multiplicand in a_q and shifts the multiplier out of lo_q;
  // divider shifts the dividend out of lo_q while quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q    <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      count_q   <= 5'd0;
      primed_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      if (state_q == IDLE && start && !flush) begin
        func_q   <= func3;
        a_q      <= operand_a;
        b_q      <= operand_b;
        count_q  <= 5'd0;
        primed_q <= 1'b0;
      end else if ((state_q == MUL || state_q == DIV) && !flush) begin
        if (!primed_q) begin
          a_q       <= mag_a;
          b_q       <= mag_b;
          hi_q      <= 32'd0;
          lo_q      <= is_div ? mag_a : mag_b;
          neg_q     <= sign_a ^ sign_b;
          neg_rem_q <= sign_a;
          primed_q  <= 1'b1;
        end else begin
          hi_q    <= is_div ? div_hi_n : mul_hi_n;
          lo_q    <= is_div ? div_lo_n : mul_lo_n;
          count_q <= count_q + 5'd1;
        end
      end
      if (load_result) result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latencies, ignore/flush/reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation, scrambles the inputs after capture, and waits for done.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output bit busy_ok,
                               output bit got);
    @(negedge clk);
    start = 1'b1; func3 = f; operand_a = a; operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; operand_a = $urandom; operand_b = $urandom; func3 = 3'($urandom);
    lat = 0; busy_ok = 1'b1; got = 1'b0; res = 32'd0;
    if (!busy) busy_ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        got = 1'b1;
        res = result;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] res;
    int lat, done_seen;
    bit busy_ok, got;

    vecs.push_back('{"mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{"mulh_min",     3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{"mulhu_ones",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{"mulhsu_ones",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{"mul_big",      3'b000, 32'h0001_0000,  32'h0001_0003, 32'h0003_0000, 33});
    vecs.push_back('{"div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{"rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{"divu_2",       3'b101, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 33});
    vecs.push_back('{"remu_2",       3'b111, 32'hFFFF_FFF9,  32'd2,         32'd1,         33});
    vecs.push_back('{"rem_7_m2",     3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{"div_by0",      3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"remu_by0",     3'b111, 32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{"div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    #20 rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, busy_ok, got);
      checkOutput({vecs[i].name, "_done"}, {31'd0, got}, 32'd1);
      checkOutput(vecs[i].name, res, vecs[i].exp);
      checkOutput({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      checkOutput({vecs[i].name, "_busy"}, {31'd0, busy_ok}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_pulse"}, {30'd0, done, busy}, 32'd0);
    end

    // start during an operation must be ignored
    @(negedge clk);
    start = 1'b1; func3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0; got = 1'b0; res = 32'd0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin
        start = 1'b1; func3 = 3'b000; operand_a = 32'd9; operand_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1; res = result;
        break;
      end
    end
    checkOutput("ignore_done", {31'd0, got}, 32'd1);
    checkOutput("ignore_result", res, 32'd14);
    checkOutput("ignore_lat", lat, 33);

    // flush mid-operation: no done, busy drops, old result retained
    @(negedge clk);
    start = 1'b1; func3 = 3'b101; operand_a = 32'd200; operand_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_done", {31'd0, done}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("flush_no_done", done_seen, 0);
    checkOutput("flush_result_kept", result, 32'd14);
    applyStimulus(3'b000, 32'd3, 32'd4, res, lat, busy_ok, got);
    checkOutput("post_flush_mul", res, 32'd12);
    checkOutput("post_flush_lat", lat, 33);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; func3 = 3'b100; operand_a = 32'd1000; operand_b = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i < 15; i++) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    checkOutput("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("arst_no_stale_done", done_seen, 0);
    applyStimulus(3'b110, 32'd17, 32'd5, res, lat, busy_ok, got);
    checkOutput("arst_new_rem", res, 32'd2);
    checkOutput("arst_new_lat", lat, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
